// File: rtl/iis_tx_frame.sv
// I2S master transmitter: 64-bclk frames, 32-bit left/right words MSB first,
// one-bit delay after each ws edge, single-entry sample holding register.
module iis_tx_frame #(
  parameter int UCNT_W = 8
) (
  input  logic              bclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [31:0]       sample_L,
  input  logic [31:0]       sample_R,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              ws,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [5:0]          c_q, c_d;
  logic                full_q, full_d;
  logic [31:0]         holdL_q, holdR_q, holdL_d, holdR_d;
  logic [31:0]         shL_q, shR_q, shL_d, shR_d;
  logic                ws_q, ws_d, sdata_q, sdata_d, fs_q, fs_d, und_q, und_d;
  logic [UCNT_W-1:0]   cnt_q, cnt_d;
  logic                load, accept;
  logic [5:0]          offL, offR;

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      full_q  <= 1'b0;
      holdL_q <= '0;
      holdR_q <= '0;
      shL_q   <= '0;
      shR_q   <= '0;
      ws_q    <= 1'b1;
      sdata_q <= 1'b0;
      fs_q    <= 1'b0;
      und_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      full_q  <= full_d;
      holdL_q <= holdL_d;
      holdR_q <= holdR_d;
      shL_q   <= shL_d;
      shR_q   <= shR_d;
      ws_q    <= ws_d;
      sdata_q <= sdata_d;
      fs_q    <= fs_d;
      und_q   <= und_d;
      cnt_q   <= cnt_d;
    end
  end

  // A frame, once started, always runs to c=63; enable is only honoured there.
  always_comb begin
    state_d = state_q;
    c_d     = '0;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        if (c_q == 6'd63 && !enable) state_d = DRAIN;
        else                         c_d     = c_q + 6'd1;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so the registered pins line
  // up with the counter value of the cycle they are driven in.
  always_comb begin
    load    = (state_q == RUN) && (c_q == 6'd0);
    accept  = sample_valid && !full_q;
    holdL_d = accept ? sample_L : holdL_q;
    holdR_d = accept ? sample_R : holdR_q;
    full_d  = accept ? 1'b1 : (load ? 1'b0 : full_q);
    shL_d   = shL_q;
    shR_d   = shR_q;
    if (load) begin
      shL_d = full_q ? holdL_q : '0;
      shR_d = full_q ? holdR_q : '0;
    end
    und_d = load && !full_q;
    cnt_d = (und_d && cnt_q != {UCNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    offL  = 6'd32 - c_d;
    offR  = 6'd0 - c_d;
    ws_d  = !((state_d == RUN) && !c_d[5]);
    fs_d  = (state_d == RUN) && (c_d == 6'd0);
    sdata_d = 1'b0;
    case (state_d)
      RUN: begin
        // c=0 carries the previous frame's right LSB; none exists coming out of IDLE
        if (c_d == 6'd0)       sdata_d = (state_q == RUN) && shR_d[0];
        else if (c_d <= 6'd32) sdata_d = shL_d[offL[4:0]];
        else                   sdata_d = shR_d[offR[4:0]];
      end
      DRAIN:   sdata_d = shR_d[0];
      default: sdata_d = 1'b0;
    endcase
  end

  assign sample_ready = !full_q;
  assign ws           = ws_q;
  assign sdata        = sdata_q;
  assign frame_start  = fs_q;
  assign underrun     = und_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_iis_tx_frame.sv
// Bench for iis_tx_frame: a frame-level model feeds per-cycle and per-frame
// scoreboards; an I2S receiver in the monitor recovers words from ws/sdata.
module tb_iis_tx_frame;
  logic        bclk = 1'b0, rst_n = 1'b0, enable = 1'b0, sample_valid = 1'b0;
  logic [31:0] sample_L = '0, sample_R = '0;
  logic        sample_ready, ws, sdata, frame_start, underrun;
  logic [7:0]  underrun_cnt;

  iis_tx_frame #(.UCNT_W(8)) dut (
    .bclk(bclk), .rst_n(rst_n), .enable(enable),
    .sample_L(sample_L), .sample_R(sample_R), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .ws(ws), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 bclk = ~bclk;

  typedef struct {logic ws, sd, fs, rdy, und; logic [7:0] cnt;} cyc_t;
  typedef struct {logic [31:0] l, r; logic u;} frm_t;
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;

  cyc_t cq[$];
  frm_t fq[$];
  int   total = 0, bad = 0, und_seen = 0;
  bit   chk_en = 1'b0;

  mst_t        m_st = M_IDLE;
  int          m_pos = 0, m_cnt = 0;
  bit          m_full = 1'b0, m_first = 1'b0;
  logic [31:0] m_hL = '0, m_hR = '0, m_curL = '0, m_curR = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance the model over one bclk edge and queue what the pins must show next.
  function automatic void model_edge();
    cyc_t e;
    bit   acc, und;
    acc = sample_valid && !m_full;
    und = 1'b0;
    if (m_st == M_RUN && m_pos == 0) begin
      if (m_full) begin
        m_curL = m_hL; m_curR = m_hR; m_full = 1'b0;
        fq.push_back('{l: m_hL, r: m_hR, u: 1'b0});
      end else begin
        m_curL = '0; m_curR = '0; und = 1'b1;
        if (m_cnt < 255) m_cnt++;
        fq.push_back('{l: 32'h0, r: 32'h0, u: 1'b1});
      end
      m_first = 1'b0;
    end
    if (acc) begin m_full = 1'b1; m_hL = sample_L; m_hR = sample_R; end
    case (m_st)
      M_IDLE:  if (enable) begin m_st = M_RUN; m_pos = 0; m_first = 1'b1; end
      M_RUN:   if (m_pos == 63 && !enable) begin m_st = M_DRAIN; m_pos = 0; end
               else m_pos = (m_pos + 1) % 64;
      default: m_st = M_IDLE;
    endcase
    e.ws  = !(m_st == M_RUN && m_pos < 32);
    e.fs  = (m_st == M_RUN && m_pos == 0);
    e.rdy = !m_full;
    e.und = und;
    e.cnt = 8'(m_cnt);
    if (m_st == M_IDLE)       e.sd = 1'b0;
    else if (m_st == M_DRAIN) e.sd = m_curR[0];
    else if (m_pos == 0)      e.sd = m_first ? 1'b0 : m_curR[0];
    else if (m_pos <= 32)     e.sd = m_curL[32 - m_pos];
    else                      e.sd = m_curR[64 - m_pos];
    cq.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge bclk);
    model_edge();
    #1;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_st == M_RUN && m_pos == p) && n < 200) begin cyc(); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_pos%0d: got timeout want c=%0d", p, p);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ws"}, 32'(ws), 1);
    chk({tag, "_sdata"}, 32'(sdata), 0);
    chk({tag, "_ready"}, 32'(sample_ready), 1);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_und"}, 32'(underrun), 0);
    chk({tag, "_cnt"}, 32'(underrun_cnt), 0);
  endtask

  // Monitor: per-cycle scoreboard plus an I2S receiver recovering each frame.
  initial begin : monitor
    cyc_t        e;
    frm_t        f;
    logic        pws;
    int          ph, k;
    logic [31:0] rl, rr;
    logic        ru;
    pws = 1'b1; ph = 0; k = 0; rl = '0; rr = '0; ru = 1'b0;
    forever begin
      @(negedge bclk);
      if (!chk_en) begin pws = 1'b1; ph = 0; continue; end
      if (underrun) und_seen++;
      if (cq.size() > 0) begin
        e = cq.pop_front();
        total++;
        if (e.ws !== ws || e.sd !== sdata || e.fs !== frame_start ||
            e.rdy !== sample_ready || e.und !== underrun || e.cnt !== underrun_cnt) begin
          bad++;
          $display("FAIL cycle t=%0t: ws %b/%b sd %b/%b fs %b/%b rdy %b/%b und %b/%b cnt %0d/%0d (got/want)",
                   $time, ws, e.ws, sdata, e.sd, frame_start, e.fs, sample_ready, e.rdy,
                   underrun, e.und, underrun_cnt, e.cnt);
        end
      end
      if (ph == 1) begin
        rl = {rl[30:0], sdata}; ru = ru | underrun; k++;
        if (k == 32) ph = 0;
      end else if (ph == 2) begin
        rr = {rr[30:0], sdata}; k++;
        if (k == 32) begin
          ph = 0;
          total++;
          if (fq.size() == 0) begin
            bad++;
            $display("FAIL frame: got L=%h R=%h want none", rl, rr);
          end else begin
            f = fq.pop_front();
            if (f.l !== rl || f.r !== rr || f.u !== ru) begin
              bad++;
              $display("FAIL frame: got L=%h R=%h u=%b want L=%h R=%h u=%b", rl, rr, ru, f.l, f.r, f.u);
            end
          end
        end
      end
      if (pws && !ws) begin ph = 1; k = 0; ru = 1'b0; end
      else if (!pws && ws) begin ph = 2; k = 0; end
      pws = ws;
    end
  end

  initial begin : driver
    int u0, n;
    #12;
    chk_reset("reset");
    @(posedge bclk); #1;
    rst_n = 1'b1; chk_en = 1'b1;
    cyc();

    // one frame with nothing buffered, then stop
    enable = 1'b1; cyc();
    wait_pos(63);
    enable = 1'b0; cyc(); cyc(); cyc();
    chk("cnt_one", 32'(underrun_cnt), 1);

    // preload while idle, then stream 8 pairs as ready rises
    sample_L = 32'h8000_0001; sample_R = 32'h7FFF_FFFE; sample_valid = 1'b1; cyc();
    sample_valid = 1'b0; cyc(); cyc();
    chk("preload_ready_low", 32'(sample_ready), 0);
    enable = 1'b1; cyc();
    u0 = und_seen;
    for (int i = 0; i < 8; i++) begin
      wait_pos(1);
      sample_L = $urandom; sample_R = $urandom; sample_valid = 1'b1; cyc();
      sample_valid = 1'b0;
    end

    // first offered in c=0 of an empty-buffer frame
    n = 0;
    while (!(m_st == M_RUN && m_pos == 0 && !m_full) && n < 300) begin cyc(); n++; end
    chk("stream_no_underrun", 32'(und_seen - u0), 0);
    sample_L = $urandom; sample_R = $urandom | 32'h1; sample_valid = 1'b1; cyc();
    sample_valid = 1'b0; cyc();
    chk("c0_offer_underrun", 32'(und_seen - u0), 1);

    // drop enable mid-frame while that pair is on the wire
    wait_pos(0);
    wait_pos(10);
    enable = 1'b0;
    n = 0;
    while (m_st != M_IDLE && n < 200) begin cyc(); n++; end
    for (int i = 0; i < 4; i++) cyc();
    chk("idle_ws", 32'(ws), 1);

    // long starvation saturates the counter
    enable = 1'b1;
    for (int i = 0; i < 300 * 64; i++) cyc();
    chk("cnt_sat", 32'(underrun_cnt), 255);

    // reset in the middle of a frame
    wait_pos(20);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset("midreset");
    cq.delete(); fq.delete();
    @(posedge bclk); #1;
    chk_reset("held_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iis_tx_frame.md
# iis_tx_frame

I2S master transmitter in the `bclk` domain, directly upstream of the I2S PCM receiver. It generates `ws` from a 64-bclk frame counter and serializes one 32-bit left and one 32-bit right sample per frame, MSB first, in standard I2S format with a one-bit delay after each `ws` edge. Samples enter through a single-entry holding register with a valid/ready handshake. Empty-buffer frames are flagged as underruns and counted.

## Interface
- `UCNT_W`, default 8: width of the saturating underrun counter.
- `bclk`, input, 1: bit clock; all logic on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: run request; sampled every cycle.
- `sample_L`, input, 32: left sample, two's complement.
- `sample_R`, input, 32: right sample, two's complement.
- `sample_valid`, input, 1: `sample_L` and `sample_R` are valid.
- `sample_ready`, output, 1: holding register empty; the pair is accepted on an edge where `sample_valid` and `sample_ready` are both high.
- `ws`, output, 1: word select; 0 = left, 1 = right.
- `sdata`, output, 1: serial data.
- `frame_start`, output, 1: one-cycle pulse in frame cycle 0.
- `underrun`, output, 1: one-cycle pulse in frame cycle 1 of a frame sent without a buffered sample.
- `underrun_cnt`, output, `UCNT_W`: saturating count of underrun frames.

## Operation
- State machine with three states: IDLE, RUN and DRAIN. A 6-bit frame counter `c` counts 0..63 in RUN and is held at 0 otherwise.
- All outputs are registered. Values given "in cycle c" are the values driven during the bclk period in which the counter equals c.
- IDLE:
  - Outputs: `ws`=1, `sdata`=0, `frame_start`=0.
  - Transition: `enable`=1 → RUN; the first RUN cycle is c=0.
- RUN, output mapping:
  - `ws` = 0 for c=0..31 and 1 for c=32..63.
  - `frame_start`=1 only when c=0.
  - `sdata` in cycle c=1..32 = `shL[32-c]` (MSB at c=1, LSB at c=32).
  - `sdata` in cycle c=33..63 = `shR[64-c]` (MSB at c=33, bit 1 at c=63).
  - `sdata` in cycle c=0 = `shR[0]` of the previous frame (0 for the first frame after IDLE).
- RUN, transitions:
  - c wraps 63→0.
  - At c=63 with `enable`=0 → DRAIN.
  - `enable` dropping at any other point does not interrupt the frame; the frame always completes.
- DRAIN: lasts one cycle; `ws`=1, `sdata` = previous-frame `shR[0]`, `frame_start`=0; then → IDLE unconditionally.
- Holding register:
  - A full flag plus 64 data bits; `sample_ready` = not full.
  - Accept on an edge where `sample_valid` and `sample_ready` are both high; full is set on that edge.
- Frame load, on the edge ending RUN cycle c=0:
  - If full: copy the holding register into `shL`/`shR` and clear full. `sample_ready` rises in cycle c=1.
  - If empty: load `shL`/`shR` with 0 and pulse `underrun` in cycle c=1. `underrun_cnt` increments on the same edge and saturates at 2^UCNT_W−1.
- Simultaneous accept and load with the register empty in cycle c=0: the accepted pair is stored, that frame underruns, and the pair is used in the next frame.
- No load occurs in IDLE or DRAIN. A pair accepted while idle is held and transmitted in the first frame after `enable` rises.

## Timing
- Reset values: state IDLE, c=0, `ws`=1, `sdata`=0, `sample_ready`=1, `frame_start`=0, `underrun`=0, `underrun_cnt`=0, full=0, `shL`=`shR`=0.
- Reset asserted mid-frame forces all of the above immediately; no partial word completes.
- Latency from an accepted pair (register previously empty, accepted before c=0) to its left MSB on `sdata`: that pair's MSB appears in the next cycle c=1.
- Frame period is exactly 64 bclk; `ws` toggles every 32 bclk while in RUN.
- Only one pair can be buffered beyond the frame currently being serialized; `sample_ready` is low for the rest of the frame after an accept.

## Test plan
- Reset, then `enable`=1 with no sample: `ws` low for c=0..31 and high for c=32..63; `sdata`=0 throughout; `underrun` pulses in c=1; `underrun_cnt`=1.
- Pre-load L=0x80000001, R=0x7FFFFFFE, then enable:
  - Left: `sdata`=1 at c=1, 0 at c=2..31, 1 at c=32.
  - Right: `sdata`=0 at c=33, 1 at c=34..63, 0 at c=0 of the next frame.
  - `sample_ready` goes 1 in c=1.
- Stream 8 pairs, each presented in the cycle `sample_ready` rises: no `underrun`. A receiver model recovers all 8 pairs bit-exact and in order.
- Present a pair first in cycle c=0 with the register empty: `underrun` pulses for that frame, and the pair is transmitted in the following frame.
- Drop `enable` at c=10:
  - The frame completes; at c=63 the state goes to DRAIN.
  - The DRAIN cycle drives the right LSB with `ws`=1.
  - IDLE follows: `ws`=1, `sdata`=0, no further `frame_start`.
- Run 300 empty frames with `UCNT_W`=8: `underrun_cnt` saturates at 255. Asserting `rst_n` low mid-frame returns every output to its reset value.
